md_issue_ctrl: RTL and testbench

//  Issue/stall controller on the pipeline side of the HI/LO multiply-divide unit.

---
 rtl/md_issue_ctrl_if.sv | 29 ++
 rtl/md_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_md_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl_if
// Link between the issue/stall controller and the HI/LO multiply-divide unit.
//   e_mdop   [2:0]  controller -> unit : MDop of the op presented this cycle
//   e_rop    [1:0]  controller -> unit : HILO_Rop (01 mfhi, 10 mflo)
//   md_req          controller -> unit : Req, kills the op presented this cycle
//   md_busy         unit -> controller : Busy
// master = controller side, slave = multiply-divide unit side.
// -----------------------------------------------------------------------------
interface md_issue_ctrl_if;
   logic [2:0] e_mdop;
   logic [1:0] e_rop;
   logic       md_req;
   logic       md_busy;

   modport master (
      output e_mdop,
      output e_rop,
      output md_req,
      input  md_busy
   );

   modport slave (
      input  e_mdop,
      input  e_rop,
      input  md_req,
      output md_busy
   );
endinterface

// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
// Issue/stall controller on the pipeline side of the HI/LO multiply-divide
// unit. The D-stage mult/div or HI/LO-access class is registered into E and
// presented to the unit from there. D is stalled while the unit would still be
// busy, and the local latency model is cross-checked against the unit's Busy.
//
// Parameters
//   MUL_LAT  cycles the unit stays busy after the issue edge of mult/multu
//   DIV_LAT  cycles the unit stays busy after the issue edge of div/divu
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset (0 = reset)
//   d_mdop    in   D-stage op: 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo
//   d_rop     in   D-stage HI/LO read: 01 mfhi, 10 mflo
//   hold      in   stall from another hazard source (D frozen, bubble into E)
//   req       in   exception/interrupt request, kills the E-stage op
//   unit      if   master side of md_issue_ctrl_if (e_mdop/e_rop/md_req/md_busy)
//   stall_d   out  freeze D, insert bubble into E
//   sync_err  out  sticky flag: latency model disagreed with md_busy
// -----------------------------------------------------------------------------
module md_issue_ctrl #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2:0]             d_mdop,
   input  logic [1:0]             d_rop,
   input  logic                   hold,
   input  logic                   req,
   md_issue_ctrl_if.master        unit,
   output logic                   stall_d,
   output logic                   sync_err
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   logic [2:0]       em_q, em_d;
   logic [1:0]       er_q, er_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic             sync_err_q, sync_err_d;

   logic [2:0]       d_mdop_s;
   logic [1:0]       d_rop_s;
   logic             is_md_d;
   logic             busy_pred;
   logic             bubble;
   logic             e_live;
   logic [2:0]       e_mdop_w;
   logic             e_is_mul;
   logic             e_is_div;

   // Reserved encodings behave exactly like "no op".
   assign d_mdop_s = (d_mdop == 3'd7) ? 3'd0 : d_mdop;
   assign d_rop_s  = (d_rop  == 2'd3) ? 2'd0 : d_rop;

   // ---- D stage: hazard detection ----
   assign is_md_d   = (d_mdop_s != 3'd0) | (d_rop_s != 2'd0);
   // Busy during the issue cycle itself plus the LAT cycles counted after it.
   assign busy_pred = (cnt_q != '0) | (e_mdop_w != 3'd0);
   assign stall_d   = is_md_d & busy_pred;
   assign bubble    = stall_d | hold | req;

   always_comb begin
      em_d = d_mdop_s;
      er_d = d_rop_s;
      if (bubble) begin
         em_d = 3'd0;
         er_d = 2'd0;
      end
   end

   // ---- E stage: op presented to the unit, latency counter ----
   assign e_is_mul = (e_mdop_w == 3'd1) | (e_mdop_w == 3'd2);
   assign e_is_div = (e_mdop_w == 3'd3) | (e_mdop_w == 3'd4);

   always_comb begin
      cnt_d = cnt_q;
      if (e_is_mul) begin
         cnt_d = CNT_W'(MUL_LAT);
      end else if (e_is_div) begin
         cnt_d = CNT_W'(DIV_LAT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   assign sync_err_d = sync_err_q | (unit.md_busy != busy_pred);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         em_q       <= 3'd0;
         er_q       <= 2'd0;
         cnt_q      <= '0;
         sync_err_q <= 1'b0;
      end else begin
         em_q       <= em_d;
         er_q       <= er_d;
         cnt_q      <= cnt_d;
         sync_err_q <= sync_err_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state. A new op can never load during ISSUE/WAIT of a busy op
   // because the stall turns it into a bubble, so only ISSUE re-checks em_d.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (em_d != 3'd0) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (e_is_mul | e_is_div) begin
               state_d = ST_WAIT;
            end else if (em_d != 3'd0) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: the E op reaches the unit only in its issue cycle and only
   // when no exception kills it. em_q is nonzero only in ISSUE, so this equals
   // gating em_q with req.
   always_comb begin
      e_live = 1'b0;
      if ((state_q == ST_ISSUE) && !req) e_live = 1'b1;
   end

   assign e_mdop_w    = e_live ? em_q : 3'd0;

   assign unit.e_mdop = e_mdop_w;
   assign unit.e_rop  = er_q;
   // Held at 0 during reset so every output is quiet while reset is asserted.
   assign unit.md_req = req & reset;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] d_mdop;
   logic [1:0] d_rop;
   logic       hold;
   logic       req;
   logic       stall_d;
   logic       sync_err;
   logic       force_idle;

   md_issue_ctrl_if mif ();

   md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .d_mdop   (d_mdop),
      .d_rop    (d_rop),
      .hold     (hold),
      .req      (req),
      .unit     (mif.master),
      .stall_d  (stall_d),
      .sync_err (sync_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural multiply-divide unit: busy in the issue cycle plus 5 (mul) or
   // 10 (div) cycles after it. force_idle makes it lie about Busy.
   logic [3:0] ucnt;
   always @(posedge clk or negedge reset) begin
      if (!reset) ucnt <= 4'd0;
      else if (mif.e_mdop == 3'd1 || mif.e_mdop == 3'd2) ucnt <= 4'd5;
      else if (mif.e_mdop == 3'd3 || mif.e_mdop == 3'd4) ucnt <= 4'd10;
      else if (ucnt != 4'd0) ucnt <= ucnt - 4'd1;
   end
   assign mif.md_busy = force_idle ? 1'b0 : ((ucnt != 4'd0) || (mif.e_mdop != 3'd0));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int c;
      int m;
      int r;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   function automatic void push(input int c, input int m, input int r);
      exp_t e;
      e.c = c;
      e.m = m;
      e.r = r;
      sb.push_back(e);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: whenever an op or HI/LO read is presented to the unit, pop the
   // next expected issue and compare cycle, MDop and HILO_Rop.
   always @(negedge clk) begin
      if (reset === 1'b1 && (mif.e_mdop != 3'd0 || mif.e_rop != 2'd0)) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_issue: got e_mdop=%0d e_rop=%0d at cycle %0d, expected nothing",
                     mif.e_mdop, mif.e_rop, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("issue_cycle", cyc, mon_e.c);
            chk("e_mdop", int'(mif.e_mdop), mon_e.m);
            chk("e_rop", int'(mif.e_rop), mon_e.r);
         end
      end
   end

   // Present one instruction in D until it is accepted; returns stall cycles.
   task automatic put(input int m, input int r, output int stalls);
      d_mdop = 3'(m);
      d_rop  = 2'(r);
      stalls = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (stall_d) stalls++;
         else break;
      end
      if (stalls >= 40) chk("put_timeout", stalls, 0);
      @(posedge clk);
      #1;
      d_mdop = 3'd0;
      d_rop  = 2'd0;
   endtask

   task automatic idle(input int n);
      d_mdop = 3'd0;
      d_rop  = 2'd0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int b;
      int s;
      reset = 1'b0;
      d_mdop = 3'd0;
      d_rop = 2'd0;
      hold = 1'b0;
      req = 1'b0;
      force_idle = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // reset state
      chk("rst_stall_d", stall_d, 0);
      chk("rst_e_mdop", int'(mif.e_mdop), 0);
      chk("rst_e_rop", int'(mif.e_rop), 0);
      chk("rst_sync_err", sync_err, 0);
      reset = 1'b1;
      idle(2);

      // mult then mflo: issue c1, stall c1..c6, mflo reaches E at c8
      b = cyc;
      push(b + 1, 1, 0);
      push(b + 8, 0, 2);
      put(1, 0, s);
      chk("t1_mult_stalls", s, 0);
      put(0, 2, s);
      chk("t1_mflo_stalls", s, 6);
      idle(3);
      chk("t1_sync_err", sync_err, 0);

      // divu then mfhi: 11 stall cycles
      b = cyc;
      push(b + 1, 4, 0);
      push(b + 13, 0, 1);
      put(4, 0, s);
      put(0, 1, s);
      chk("t2_mfhi_stalls", s, 11);
      idle(3);

      // mtlo then mflo: one stall cycle, counter never loads
      b = cyc;
      push(b + 1, 6, 0);
      push(b + 3, 0, 2);
      put(6, 0, s);
      chk("t3_cnt_after_mtlo", int'(dut.cnt_q), 0);
      put(0, 2, s);
      chk("t3_mflo_stalls", s, 1);
      idle(3);

      // div killed by req in its issue cycle
      b = cyc;
      put(3, 0, s);
      d_mdop = 3'd0;
      d_rop = 2'd2;
      req = 1'b1;
      @(negedge clk);
      chk("t4_e_mdop_killed", int'(mif.e_mdop), 0);
      chk("t4_md_req", mif.md_req, 1);
      chk("t4_no_stall", stall_d, 0);
      @(posedge clk);
      #1;
      req = 1'b0;
      chk("t4_cnt_zero", int'(dut.cnt_q), 0);
      push(b + 3, 0, 2);
      put(0, 2, s);
      chk("t4_mflo_stalls", s, 0);
      idle(3);
      chk("t4_sync_err", sync_err, 0);

      // hold turns the mult into a bubble for one cycle
      b = cyc;
      d_mdop = 3'd1;
      hold = 1'b1;
      @(posedge clk);
      #1;
      hold = 1'b0;
      push(b + 2, 1, 0);
      put(1, 0, s);
      chk("t7_hold_mult_stalls", s, 0);
      idle(8);

      // reserved codes 7 / 11 never stall and never issue
      b = cyc;
      push(b + 1, 1, 0);
      put(1, 0, s);
      d_mdop = 3'd7;
      d_rop = 2'd3;
      @(negedge clk);
      chk("t8_reserved_no_stall", stall_d, 0);
      @(posedge clk);
      #1;
      idle(8);

      // async reset in the middle of WAIT (cnt=4)
      b = cyc;
      push(b + 1, 1, 0);
      put(1, 0, s);
      d_rop = 2'd1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("t5_cnt_before", int'(dut.cnt_q), 4);
      chk("t5_stall_wait", stall_d, 1);
      #2;
      reset = 1'b0;
      req = 1'b1;
      #1;
      chk("t5_rst_stall_d", stall_d, 0);
      chk("t5_rst_e_mdop", int'(mif.e_mdop), 0);
      chk("t5_rst_e_rop", int'(mif.e_rop), 0);
      chk("t5_rst_md_req", mif.md_req, 0);
      chk("t5_rst_cnt", int'(dut.cnt_q), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      req = 1'b0;
      d_rop = 2'd0;
      chk("t5_state_idle", int'(dut.state_q), 0);
      b = cyc;
      push(b + 1, 0, 1);
      put(0, 1, s);
      chk("t5_mfhi_stalls", s, 0);
      idle(3);
      chk("t5_sync_err", sync_err, 0);

      // unit drops Busy early while cnt=3: sticky sync_err
      b = cyc;
      push(b + 1, 1, 0);
      put(1, 0, s);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("t6_cnt", int'(dut.cnt_q), 3);
      force_idle = 1'b1;
      @(negedge clk);
      chk("t6_sync_err_before", sync_err, 0);
      @(posedge clk);
      #1;
      force_idle = 1'b0;
      chk("t6_sync_err_set", sync_err, 1);
      idle(12);
      chk("t6_sync_err_sticky", sync_err, 1);
      reset = 1'b0;
      #1;
      chk("t6_sync_err_cleared", sync_err, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(2);

      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
